// File: rtl/uart_rx_engine_p.sv
// UART receive engine: synchronises rx, qualifies the start bit at mid-bit, samples data at bit centres.
// Latency: frame completes on the bit-time tick of the last checked stop bit (+2 clk synchroniser delay from pad).
// Backpressure: none on the line; an unread frame is overwritten by the next one and flagged with oe.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   rx                raw serial line (idle high)
//   k                 bit period minus one in clocks (>= 3)
//   nbits             data bits per frame, clamped to 5..DW
//   pen, odd, stop2   parity enable, odd/even select, two-stop-bit check
//   rd_ack            host consumed the frame; clears rx_rdy and error flags
//   data              right-justified received word (LSB = first bit)
//   rx_rdy            frame available
//   pe, fe, oe        parity / framing / overrun error of the frame in data
//   busy              receiver not idle
module uart_rx_engine_p #(
    parameter int DW = 8,
    parameter int KW = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    input  logic [KW-1:0] k,
    input  logic [3:0]    nbits,
    input  logic          pen,
    input  logic          odd,
    input  logic          stop2,
    input  logic          rd_ack,
    output logic [DW-1:0] data,
    output logic          rx_rdy,
    output logic          pe,
    output logic          fe,
    output logic          oe,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP1,
        STOP2,
        WAITHI
    } state_t;

    state_t        state, state_nxt;
    logic          rx_m, rx_s;
    logic [KW-1:0] kc, tgt;
    logic          btu;
    logic [3:0]    n_cl, n_l, bcnt;
    logic          pen_l, odd_l, stop2_l;
    logic [DW-1:0] sr;
    logic          par_acc, par_err;
    logic          done, fe_nxt;

    // Two-flop synchroniser; resets to the idle line level so reset never fakes a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_comb begin
        if (nbits < 4'd5)
            n_cl = 4'd5;
        else if (nbits > 4'(DW))
            n_cl = 4'(DW);
        else
            n_cl = nbits;
    end

    // The start bit is timed to its half-way point, every later bit a full period on from there,
    // so all data/parity/stop samples land at bit centres.
    assign tgt = (state == START) ? (k >> 1) : k;
    assign btu = (kc == tgt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        fe_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s)
                    state_nxt = START;
            end
            START: begin
                if (btu)
                    state_nxt = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (btu && (bcnt == n_l - 4'd1))
                    state_nxt = pen_l ? PAR : STOP1;
            end
            PAR: begin
                if (btu)
                    state_nxt = STOP1;
            end
            STOP1: begin
                if (btu) begin
                    if (!rx_s) begin
                        fe_nxt    = 1'b1;
                        done      = 1'b1;
                        state_nxt = WAITHI;
                    end else if (stop2_l) begin
                        state_nxt = STOP2;
                    end else begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            STOP2: begin
                if (btu) begin
                    done = 1'b1;
                    if (!rx_s) begin
                        fe_nxt    = 1'b1;
                        state_nxt = WAITHI;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            WAITHI: begin
                // A break / stuck-low line yields one errored frame; wait for idle before re-arming.
                if (rx_s)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit-time counter restarts on every state entry and after every tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            kc <= '0;
        else if (btu || (state_nxt != state) || (state == IDLE) || (state == WAITHI))
            kc <= '0;
        else
            kc <= kc + 1'b1;
    end

    // Frame format is captured once the start bit is confirmed; later input changes do not
    // affect the frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_l     <= 4'd5;
            pen_l   <= 1'b0;
            odd_l   <= 1'b0;
            stop2_l <= 1'b0;
            bcnt    <= '0;
            sr      <= '0;
            par_acc <= 1'b0;
            par_err <= 1'b0;
        end else if ((state == START) && (state_nxt == DATA)) begin
            n_l     <= n_cl;
            pen_l   <= pen;
            odd_l   <= odd;
            stop2_l <= stop2;
            bcnt    <= '0;
            sr      <= '0;
            par_acc <= 1'b0;
            par_err <= 1'b0;
        end else if ((state == DATA) && btu) begin
            // Write each bit straight into its final position so the word is right-justified
            // for any frame length.
            for (int i = 0; i < DW; i++) begin
                if (bcnt == 4'(i))
                    sr[i] <= rx_s;
            end
            par_acc <= par_acc ^ rx_s;
            bcnt    <= bcnt + 4'd1;
        end else if ((state == PAR) && btu) begin
            par_err <= odd_l ? ~(par_acc ^ rx_s) : (par_acc ^ rx_s);
        end
    end

    // Host-side registers: a completing frame takes priority over a same-cycle acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data   <= '0;
            rx_rdy <= 1'b0;
            pe     <= 1'b0;
            fe     <= 1'b0;
            oe     <= 1'b0;
        end else if (done) begin
            data   <= sr;
            pe     <= par_err & pen_l;
            fe     <= fe_nxt;
            oe     <= rx_rdy & ~rd_ack;
            rx_rdy <= 1'b1;
        end else if (rd_ack) begin
            rx_rdy <= 1'b0;
            pe     <= 1'b0;
            fe     <= 1'b0;
            oe     <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_engine_p.sv
// Testbench for uart_rx_engine_p: serial frames built from field values, expected results
// computed from frame contents and bit timing, directed corner cases then random frames.
module tb_uart_rx_engine_p;
    localparam int DW = 8;
    localparam int KW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic [KW-1:0] k;
    logic [3:0]    nbits;
    logic          pen, odd, stop2, rd_ack;
    logic [DW-1:0] data;
    logic          rx_rdy, pe, fe, oe, busy;

    int            n_chk = 0;
    int            n_err = 0;
    bit            mdl_rdy = 1'b0;
    logic [DW-1:0] mdl_data = '0;

    uart_rx_engine_p #(.DW(DW), .KW(KW)) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .k      (k),
        .nbits  (nbits),
        .pen    (pen),
        .odd    (odd),
        .stop2  (stop2),
        .rd_ack (rd_ack),
        .data   (data),
        .rx_rdy (rx_rdy),
        .pe     (pe),
        .fe     (fe),
        .oe     (oe),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_ack();
        @(posedge clk); #1 rd_ack = 1'b1;
        @(posedge clk); #1 rd_ack = 1'b0;
        chk("ack_rdy", rx_rdy, 0);
        chk("ack_pe", pe, 0);
        chk("ack_fe", fe, 0);
        chk("ack_oe", oe, 0);
        chk("ack_data", data, mdl_data);
        mdl_rdy = 1'b0;
    endtask

    // Drives one frame on rx (rx changes 1 time unit after a rising edge) and checks the
    // completion exactly at the predicted cycle.
    task automatic send_frame(input int kk, input int nb, input bit p_en, input bit p_odd,
                              input bit s2, input logic [8:0] d, input bit par_ok,
                              input bit st1, input bit st2b, input bit ack_at_done,
                              input int hold_low, input bit ack_after);
        int            n, lidx, t_done, bits_end, total;
        bit            q[$];
        logic [8:0]    mask;
        logic [DW-1:0] e_data;
        bit            xr, pbit, e_pe, e_fe, e_oe;

        n      = (nb < 5) ? 5 : ((nb > DW) ? DW : nb);
        mask   = (9'd1 << n) - 9'd1;
        e_data = DW'(d & mask);
        xr     = ^(d & mask);
        pbit   = p_odd ? ~xr : xr;
        if (!par_ok) pbit = ~pbit;

        k = KW'(kk); nbits = 4'(nb); pen = p_en; odd = p_odd; stop2 = s2;

        q.push_back(1'b0);
        for (int i = 0; i < n; i++) q.push_back(d[i]);
        if (p_en) q.push_back(pbit);
        q.push_back(st1);
        if (s2) q.push_back(st2b);

        e_pe = p_en & ~par_ok;
        e_fe = ~st1 | (s2 & ~st2b);
        e_oe = mdl_rdy & ~ack_at_done;
        // Index of the last bit the receiver samples (start bit = 0); the frame ends early
        // at a bad first stop bit.
        lidx   = 1 + n + int'(p_en) + ((st1 && s2) ? 1 : 0);
        // 2 sync flops + 1 IDLE cycle, half-bit start qualification, then full bit periods.
        t_done   = 3 + kk / 2 + (kk + 1) * lidx;
        bits_end = (kk + 1) * q.size();
        total    = bits_end + hold_low + kk + 4;

        for (int t = 0; t < total; t++) begin
            @(posedge clk); #1;
            if (t == t_done) begin
                chk("pre_rdy", rx_rdy, mdl_rdy);
                rd_ack = ack_at_done;
            end else if (t == t_done + 1) begin
                rd_ack = 1'b0;
                chk("data", data, e_data);
                chk("rdy", rx_rdy, 1);
                chk("pe", pe, e_pe);
                chk("fe", fe, e_fe);
                chk("oe", oe, e_oe);
                mdl_rdy  = 1'b1;
                mdl_data = e_data;
            end else if (ack_after && t == t_done + 3) begin
                rd_ack = 1'b1;
            end else if (ack_after && t == t_done + 4) begin
                rd_ack = 1'b0;
                chk("ack_after_rdy", rx_rdy, 0);
                mdl_rdy = 1'b0;
            end
            // Format inputs change mid-frame; the frame in flight must not notice.
            if (t == 2 * (kk + 1)) begin
                nbits = 4'($urandom); pen = 1'($urandom);
                odd = 1'($urandom); stop2 = 1'($urandom);
            end
            if (hold_low > 0 && t == bits_end + hold_low - 1) begin
                chk("stuck_busy", busy, 1);
                chk("stuck_rdy", rx_rdy, mdl_rdy);
            end
            if (t < bits_end)
                rx = q[t / (kk + 1)];
            else
                rx = (t < bits_end + hold_low) ? 1'b0 : 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; rd_ack = 1'b0;
        k = KW'(9); nbits = 4'd8; pen = 1'b0; odd = 1'b0; stop2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", data, 0);
        chk("rst_rdy", rx_rdy, 0);
        chk("rst_pe", pe, 0);
        chk("rst_fe", fe, 0);
        chk("rst_oe", oe, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // 8N1 0x55, then acknowledge
        send_frame(9, 8, 0, 0, 0, 9'h055, 1, 1, 1, 0, 0, 0);
        do_ack();

        // 3-clock glitch: START lasts 5 clocks, then back to IDLE with no frame
        @(posedge clk); #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("glitch_busy_hi", busy, 1);
        @(posedge clk);
        #1 chk("glitch_busy_lo", busy, 0);
        chk("glitch_rdy", rx_rdy, 0);
        repeat (20) @(posedge clk);
        #1 chk("glitch_rdy_late", rx_rdy, 0);

        // 8E1 0x07: wrong parity bit, then correct one
        send_frame(9, 8, 1, 0, 0, 9'h007, 0, 1, 1, 0, 0, 0);
        do_ack();
        send_frame(9, 8, 1, 0, 0, 9'h007, 1, 1, 1, 0, 0, 0);
        do_ack();

        // Bad stop bit followed by a 200-clock stuck-low line, then a clean frame
        send_frame(9, 8, 0, 0, 0, 9'h03C, 1, 0, 1, 0, 200, 1);
        send_frame(9, 8, 0, 0, 0, 9'h0C3, 1, 1, 1, 0, 0, 0);
        do_ack();

        // Overrun, then overrun masked by a coincident acknowledge
        send_frame(9, 8, 0, 0, 0, 9'h0A3, 1, 1, 1, 0, 0, 0);
        send_frame(9, 8, 0, 0, 0, 9'h0A3, 1, 1, 1, 0, 0, 0);
        send_frame(9, 8, 0, 0, 0, 9'h0A3, 1, 1, 1, 1, 0, 0);
        do_ack();

        // 7O2 0x41 with a bad second stop bit
        send_frame(15, 7, 1, 1, 1, 9'h041, 1, 1, 0, 0, 0, 0);

        // Reset in the middle of the data bits
        @(posedge clk); #1 rx = 1'b0;
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_data", data, 0);
        chk("mid_rst_rdy", rx_rdy, 0);
        chk("mid_rst_pe", pe, 0);
        chk("mid_rst_fe", fe, 0);
        chk("mid_rst_oe", oe, 0);
        chk("mid_rst_busy", busy, 0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mdl_rdy = 1'b0; mdl_data = '0;
        repeat (4) @(posedge clk);
        send_frame(9, 8, 0, 0, 0, 9'h05A, 1, 1, 1, 0, 0, 0);

        // Random frames: all formats, length clamping, parity/stop errors, ack timing
        for (int it = 0; it < 25; it++) begin
            int         kk, nb;
            bit         p_en, p_odd, s2, par_ok, st1, st2b, ack_c;
            logic [8:0] d;
            kk     = int'($urandom_range(5, 20));
            nb     = int'($urandom_range(3, 11));
            p_en   = 1'($urandom);
            p_odd  = 1'($urandom);
            s2     = 1'($urandom);
            d      = 9'($urandom);
            par_ok = ($urandom % 4) != 0;
            st1    = ($urandom % 5) != 0;
            st2b   = ($urandom % 5) != 0;
            ack_c  = ($urandom % 4) == 0;
            if (mdl_rdy && ($urandom % 2) == 1)
                do_ack();
            send_frame(kk, nb, p_en, p_odd, s2, d, par_ok, st1, st2b, ack_c, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_engine_p.md
Name: uart_rx_engine_p

Overview:
- Parametrised UART receive engine: synchronises the serial line, validates the start bit at mid-bit, and samples data at bit centres.
- Configurable data length, optional odd/even parity, 1 or 2 stop bits.
- Assembles a right-justified data word and reports parity, framing and overrun errors through a ready/acknowledge handshake to the host-side register interface.
- Sits between the RX pad and the UART status/data registers, next to the transmit engine.

Parameters:
- DW, 8, maximum data bits per frame (5..9); width of data port.
- KW, 19, width of bit-time count input k.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- rx  input  1  raw serial line, idle high
- k  input  KW  bit period minus one, in clocks (bit time = k+1 clocks); must be >= 3
- nbits  input  4  data bits per frame; values <5 treated as 5, >DW treated as DW
- pen  input  1  parity enable
- odd  input  1  1 = odd parity, 0 = even parity
- stop2  input  1  1 = two stop bits checked
- rd_ack  input  1  one-cycle pulse: host consumed data, clears rx_rdy and flags
- data  output  DW  received word, LSB = first bit, unused upper bits 0
- rx_rdy  output  1  new frame available
- pe  output  1  parity error of frame in data
- fe  output  1  framing error of frame in data
- oe  output  1  overrun: previous frame unread when this one completed
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset: async, all state to IDLE. data=0; rx_rdy, pe, fe, oe=0; busy=0. The two-flop rx synchroniser resets to 1. Reset mid-frame discards the frame.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
- Bit-time counter kc (KW bits): cleared on every state entry; BTU when kc == target, then kc clears. Target is k>>1 in START and k otherwise.
- States: IDLE, START, DATA, PAR, STOP1, STOP2, WAITHI.
- IDLE: rx_s==0 -> START.
- START: at BTU (half bit):
  - rx_s==1 -> IDLE (glitch rejected, no flags).
  - rx_s==0 -> DATA. Latch nbits (clamped), pen, odd and stop2 here; later changes to them are ignored for this frame.
- DATA: at each BTU sample rx_s into the shift register, LSB first. After the latched nbits samples -> PAR if pen, else STOP1.
- PAR: at BTU sample the parity bit.
  - Error if even mode and XOR(data, parity bit) = 1.
  - Error if odd mode and XOR(data, parity bit) = 0.
  - -> STOP1.
- STOP1: at BTU sample rx_s.
  - rx_s==0 -> frame error, complete frame, -> WAITHI.
  - rx_s==1 and stop2 -> STOP2.
  - Otherwise complete frame, -> IDLE.
- STOP2: at BTU sample rx_s. 0 -> frame error, complete frame, -> WAITHI; 1 -> complete frame, -> IDLE.
- WAITHI: stay until rx_s==1, then -> IDLE. Break or stuck-low lines produce exactly one errored frame, not repeated frames.
- Frame completion (single cycle):
  - data <= assembled word, right-justified.
  - pe, fe <= computed values; pe=0 when parity is disabled.
  - oe <= rx_rdy & ~rd_ack.
  - rx_rdy <= 1.
- rd_ack without completion in the same cycle: rx_rdy, pe, fe, oe <= 0; data holds.
- rd_ack together with completion: completion wins; rx_rdy stays 1, oe=0.
- Overrun: data and flags are overwritten by the new frame; oe=1.
- Latency: completion occurs at the BTU of the last stop bit sampled, plus 2 synchroniser cycles relative to the pad.
- Next start edge is detectable from the cycle after returning to IDLE, i.e. mid stop bit.

Test Plan:
- k=9, 8N1, rx frame 0x55 -> at last-stop BTU: data=0x55, rx_rdy=1, pe=fe=oe=0. rd_ack -> rx_rdy=0.
- k=9, rx low for 3 clocks then high -> returns to IDLE after the 5th START-state clock; rx_rdy stays 0; busy drops.
- k=9, 8E1, data 0x07 with parity bit 0 -> data=0x07, pe=1. Same frame with parity bit 1 -> pe=0.
- k=9, 8N1, stop bit 0 and rx held low for 200 clocks -> one completion with fe=1; no further rx_rdy events until rx is high and a new start bit arrives.
- Two 0xA3 frames, no rd_ack between -> second completion: oe=1, data=0xA3. Repeat with rd_ack coincident with the second completion -> rx_rdy=1, oe=0.
- k=15, nbits=7, odd parity, stop2, frame 0x41 with second stop bit 0 -> data=0x41 (bit 7 = 0), pe=0, fe=1. Assert rst mid-DATA -> all outputs 0, state IDLE.
